// File: rtl/rps_gfx_pkg.sv
// Shared constants, FSM state type and width helper for the RPS graphics path.
package rps_gfx_pkg;

  // Sprite bank indices
  localparam int unsigned SPR_ROCK    = 0;
  localparam int unsigned SPR_SCISSOR = 1;
  localparam int unsigned SPR_PAPER   = 2;

  // 3-bit RGB colours (one bit per channel)
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_WHITE = 3'b111;

  // Default framebuffer size
  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} blit_state_e;

  // Index width for n items; never below one bit so degenerate sizes still elaborate.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_scan_ctr.sv
// Row-major scan position for a sprite: column, row and the linear ROM address,
// with a flag marking the final pixel. The address is a plain incrementer.
module sprite_scan_ctr
  import rps_gfx_pkg::*;
#(
  parameter int unsigned IMG_W = 80,
  parameter int unsigned IMG_H = 120,
  localparam int unsigned COL_BITS  = bits_for(IMG_W),
  localparam int unsigned ROW_BITS  = bits_for(IMG_H),
  localparam int unsigned ADDR_BITS = bits_for(IMG_W * IMG_H)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 advance,
  output logic [COL_BITS-1:0]  col,
  output logic [ROW_BITS-1:0]  row,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 last
);

  logic col_end;
  logic row_end;

  // End-of-line / end-of-image detection
  always_comb begin
    col_end = (col == COL_BITS'(IMG_W - 1));
    row_end = (row == ROW_BITS'(IMG_H - 1));
    last    = col_end && row_end;
  end

  // Counters step once per pixel; everything wraps to zero after the last pixel
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies one monochrome sprite from an external ROM bank into the vga_adapter
// framebuffer at a run-time origin, with per-draw colours, optional transparent
// background and edge clipping. start/busy/done handshake.
module sprite_blitter
  import rps_gfx_pkg::*;
#(
  parameter int unsigned IMG_W       = 80,
  parameter int unsigned IMG_H       = 120,
  parameter int unsigned NUM_SPRITES = 3,
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned COLOUR_BITS = 3,
  parameter int unsigned ROM_LAT     = 1,
  localparam int unsigned X_BITS    = bits_for(SCREEN_W),
  localparam int unsigned Y_BITS    = bits_for(SCREEN_H),
  localparam int unsigned SEL_BITS  = bits_for(NUM_SPRITES),
  localparam int unsigned ADDR_BITS = bits_for(IMG_W * IMG_H),
  localparam int unsigned COL_BITS  = bits_for(IMG_W),
  localparam int unsigned ROW_BITS  = bits_for(IMG_H)
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [SEL_BITS-1:0]    sel,
  input  logic [X_BITS-1:0]      x0,
  input  logic [Y_BITS-1:0]      y0,
  input  logic [COLOUR_BITS-1:0] fg_colour,
  input  logic [COLOUR_BITS-1:0] bg_colour,
  input  logic                   transparent,
  output logic [ADDR_BITS-1:0]   rom_addr,
  input  logic [NUM_SPRITES-1:0] rom_q,
  output logic [X_BITS-1:0]      vga_x,
  output logic [Y_BITS-1:0]      vga_y,
  output logic [COLOUR_BITS-1:0] vga_colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  blit_state_e state_q, state_d;
  logic [1:0]  flush_q, flush_d;
  logic        load;
  logic        scanning;

  logic [SEL_BITS-1:0]    sel_q;
  logic [X_BITS-1:0]      x0_q;
  logic [Y_BITS-1:0]      y0_q;
  logic [COLOUR_BITS-1:0] fg_q;
  logic [COLOUR_BITS-1:0] bg_q;
  logic                   transp_q;

  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic                last;

  logic [COL_BITS-1:0] col_pipe [ROM_LAT];
  logic [ROW_BITS-1:0] row_pipe [ROM_LAT];
  logic [ROM_LAT-1:0]  vld_pipe;

  logic                   pix_bit;
  logic [X_BITS:0]        x_full;
  logic [Y_BITS:0]        y_full;
  logic                   pix_plot;
  logic [COLOUR_BITS-1:0] pix_colour;

  sprite_scan_ctr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_scan_ctr (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .clear    (load),
    .advance  (scanning),
    .col      (col),
    .row      (row),
    .addr     (rom_addr),
    .last     (last)
  );

  // Next-state logic and handshake outputs
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    load     = 1'b0;
    scanning = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load    = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        scanning = 1'b1;
        if (last) begin
          flush_d = '0;
          state_d = FLUSH;
        end
      end
      // ROM_LAT+1 cycles: ROM read latency plus the output register
      FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (flush_q == 2'(ROM_LAT)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Per-draw attributes captured at start; an out-of-range sprite index falls back to 0
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sel_q    <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      transp_q <= 1'b0;
    end else if (load) begin
      sel_q    <= (32'(sel) < NUM_SPRITES) ? sel : SEL_BITS'(SPR_ROCK);
      x0_q     <= x0;
      y0_q     <= y0;
      fg_q     <= fg_colour;
      bg_q     <= bg_colour;
      transp_q <= transparent;
    end
  end

  // Position and valid travel alongside the ROM so they line up with rom_q
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(ROM_LAT); i++) begin
        col_pipe[i] <= '0;
        row_pipe[i] <= '0;
      end
      vld_pipe <= '0;
    end else begin
      col_pipe[0] <= col;
      row_pipe[0] <= row;
      vld_pipe[0] <= scanning;
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        col_pipe[i] <= col_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // Pixel mux: colour select, transparency and clipping (one extra bit so no wrap)
  always_comb begin
    pix_bit    = rom_q[sel_q];
    x_full     = (X_BITS+1)'(x0_q) + (X_BITS+1)'(col_pipe[ROM_LAT-1]);
    y_full     = (Y_BITS+1)'(y0_q) + (Y_BITS+1)'(row_pipe[ROM_LAT-1]);
    pix_colour = pix_bit ? bg_q : fg_q;
    pix_plot   = vld_pipe[ROM_LAT-1]
              && (x_full < (X_BITS+1)'(SCREEN_W))
              && (y_full < (Y_BITS+1)'(SCREEN_H))
              && !(pix_bit && transp_q);
  end

  // Output register; coordinates and colour hold while nothing is plotted
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      plot <= pix_plot;
      if (pix_plot) begin
        vga_x      <= x_full[X_BITS-1:0];
        vga_y      <= y_full[Y_BITS-1:0];
        vga_colour <= pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a 4x2 / ROM_LAT=1 instance and a default 80x120 / ROM_LAT=3
// instance, each fed by a behavioural ROM. Expected plots are queued at launch and
// popped as the DUT plots.
module tb_sprite_blitter;
  import rps_gfx_pkg::*;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int         sel;
    int         x0;
    int         y0;
    logic [2:0] fg;
    logic [2:0] bg;
    bit         tr;
    int         n_plot;
  } vec_t;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;
  logic reset_n;

  // Small instance signals
  logic       start_s, tr_s, plot_s, busy_s, done_s;
  logic [1:0] sel_s;
  logic [7:0] x0_s, vx_s;
  logic [6:0] y0_s, vy_s;
  logic [2:0] fg_s, bg_s, vc_s, rom_addr_s, rom_q_s;
  // Large instance signals
  logic        start_l, tr_l, plot_l, busy_l, done_l;
  logic [1:0]  sel_l;
  logic [7:0]  x0_l, vx_l;
  logic [6:0]  y0_l, vy_l;
  logic [2:0]  fg_l, bg_l, vc_l, rom_q_l;
  logic [13:0] rom_addr_l;

  sprite_blitter #(.IMG_W(4), .IMG_H(2), .ROM_LAT(1)) dut_s (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start_s), .sel(sel_s), .x0(x0_s),
    .y0(y0_s), .fg_colour(fg_s), .bg_colour(bg_s), .transparent(tr_s),
    .rom_addr(rom_addr_s), .rom_q(rom_q_s), .vga_x(vx_s), .vga_y(vy_s),
    .vga_colour(vc_s), .plot(plot_s), .busy(busy_s), .done(done_s)
  );

  sprite_blitter #(.ROM_LAT(3)) dut_l (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start_l), .sel(sel_l), .x0(x0_l),
    .y0(y0_l), .fg_colour(fg_l), .bg_colour(bg_l), .transparent(tr_l),
    .rom_addr(rom_addr_l), .rom_q(rom_q_l), .vga_x(vx_l), .vga_y(vy_l),
    .vga_colour(vc_l), .plot(plot_l), .busy(busy_l), .done(done_l)
  );

  // Small ROM bank, latency 1: rock all-0, scissor checkerboard, paper 8'hC3
  logic [7:0] mem_s [3];
  always @(posedge CLOCK_50)
    rom_q_s <= {mem_s[2][rom_addr_s], mem_s[1][rom_addr_s], mem_s[0][rom_addr_s]};

  // Large ROM bank, latency 3: pattern bit = addr[0]^addr[3]
  logic [2:0] lq [3];
  always @(posedge CLOCK_50) begin
    lq[0] <= {3{rom_addr_l[0] ^ rom_addr_l[3]}};
    lq[1] <= lq[0];
    lq[2] <= lq[1];
  end
  assign rom_q_l = lq[2];

  int   n_checks = 0;
  int   n_pass   = 0;
  pix_t q_s[$];
  pix_t q_l[$];
  int   plots_s = 0, dones_s = 0, plots_l = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model for the 4x2 instance
  task automatic push_small(input int sel, input int x0, input int y0,
                            input logic [2:0] fg, input logic [2:0] bg, input bit tr);
    int   s;
    pix_t p;
    s = (sel >= 3) ? 0 : sel;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        logic b;
        int   x, y;
        b = mem_s[s][r*4 + c];
        x = x0 + c;
        y = y0 + r;
        if (x < 160 && y < 120 && !(b && tr)) begin
          p.x = 8'(x);
          p.y = 7'(y);
          p.c = b ? bg : fg;
          q_s.push_back(p);
        end
      end
    end
  endtask

  task automatic launch_small(input int sel, input int x0, input int y0,
                              input logic [2:0] fg, input logic [2:0] bg, input bit tr);
    @(posedge CLOCK_50);
    #1;
    sel_s = 2'(sel); x0_s = 8'(x0); y0_s = 7'(y0);
    fg_s = fg; bg_s = bg; tr_s = tr; start_s = 1'b1;
    @(posedge CLOCK_50);
    #1 start_s = 1'b0;
  endtask

  // Cycles counted from the start cycle (cycle 0); returns done cycle and first plot cycle
  task automatic wait_done_small(output int cyc, output int first, output bit got);
    cyc = 0; first = -1; got = 1'b0;
    while (cyc < 200 && !got) begin
      @(negedge CLOCK_50);
      cyc++;
      if (plot_s && first < 0) first = cyc;
      if (done_s) got = 1'b1;
    end
    if (!got) check("small done timeout", 0, 1);
  endtask

  // Scoreboard for the small instance
  always @(negedge CLOCK_50) begin
    pix_t p;
    if (reset_n) begin
      if (done_s) dones_s++;
      if (plot_s) begin
        plots_s++;
        if (q_s.size() == 0) check("small spare plot", 0, 1);
        else begin
          p = q_s.pop_front();
          check("small pixel {x,y,c}", {vx_s, vy_s, vc_s}, p);
        end
      end
    end
  end

  // Scoreboard for the large instance
  always @(negedge CLOCK_50) begin
    pix_t p;
    if (reset_n && plot_l) begin
      plots_l++;
      if (q_l.size() == 0) check("large spare plot", 0, 1);
      else begin
        p = q_l.pop_front();
        check("large pixel {x,y,c}", {vx_l, vy_l, vc_l}, p);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   cyc, first, d0, n_inc, max_a, prev;
    bit   got;
    pix_t p;

    reset_n = 1'b1;
    start_s = 0; sel_s = 0; x0_s = 0; y0_s = 0; fg_s = 0; bg_s = 0; tr_s = 0;
    start_l = 0; sel_l = 0; x0_l = 0; y0_l = 0; fg_l = 0; bg_l = 0; tr_l = 0;
    mem_s[0] = 8'h00;
    mem_s[1] = 8'h5A;
    mem_s[2] = 8'hC3;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("reset plot", plot_s, 0);
    check("reset busy", busy_s, 0);
    check("reset done", done_s, 0);
    check("reset rom_addr", rom_addr_s, 0);
    check("reset vga_x", vx_s, 0);
    check("reset vga_y", vy_s, 0);
    check("reset vga_colour", vc_s, 0);
    check("reset large plot", plot_l, 0);
    check("reset large busy", busy_l, 0);
    check("reset large rom_addr", rom_addr_l, 0);
    #1 reset_n = 1'b1;

    // Basic, transparency on/off, clipping, out-of-range select
    vecs[0] = '{0, 10, 5, COL_GREEN, COL_WHITE, 1'b0, 8};
    vecs[1] = '{1, 10, 5, COL_GREEN, COL_WHITE, 1'b1, 4};
    vecs[2] = '{1, 10, 5, COL_GREEN, COL_WHITE, 1'b0, 8};
    vecs[3] = '{0, 158, 119, COL_GREEN, COL_WHITE, 1'b0, 2};
    vecs[4] = '{3, 0, 0, COL_WHITE, COL_GREEN, 1'b0, 8};
    foreach (vecs[i]) begin
      plots_s = 0;
      push_small(vecs[i].sel, vecs[i].x0, vecs[i].y0, vecs[i].fg, vecs[i].bg, vecs[i].tr);
      launch_small(vecs[i].sel, vecs[i].x0, vecs[i].y0, vecs[i].fg, vecs[i].bg, vecs[i].tr);
      wait_done_small(cyc, first, got);
      check($sformatf("vec%0d done cycle", i), cyc, 11);
      check($sformatf("vec%0d first plot cycle", i), first, 3);
      check($sformatf("vec%0d busy with done", i), busy_s, 1);
      @(negedge CLOCK_50);
      check($sformatf("vec%0d busy after done", i), busy_s, 0);
      check($sformatf("vec%0d done pulse width", i), done_s, 0);
      check($sformatf("vec%0d plot count", i), plots_s, vecs[i].n_plot);
      check($sformatf("vec%0d queue empty", i), q_s.size(), 0);
    end

    // Latched inputs: change sel/x0 mid-draw and pulse start while busy
    plots_s = 0;
    d0 = dones_s;
    push_small(2, 20, 10, COL_GREEN, COL_WHITE, 1'b0);
    launch_small(2, 20, 10, COL_GREEN, COL_WHITE, 1'b0);
    sel_s = 2'd0; x0_s = 8'd50; y0_s = 7'd0;
    repeat (2) @(posedge CLOCK_50);
    #1 start_s = 1'b1;
    @(posedge CLOCK_50);
    #1 start_s = 1'b0;
    repeat (30) @(negedge CLOCK_50);
    check("latch done count", dones_s - d0, 1);
    check("latch plot count", plots_s, 8);
    check("latch queue empty", q_s.size(), 0);
    check("latch idle after", busy_s, 0);

    // Reset mid-draw after three plots
    plots_s = 0;
    push_small(0, 10, 5, COL_GREEN, COL_WHITE, 1'b0);
    launch_small(0, 10, 5, COL_GREEN, COL_WHITE, 1'b0);
    for (int i = 0; i < 50 && plots_s < 3; i++) begin
      @(negedge CLOCK_50);
      #1;
    end
    check("abort plots before reset", plots_s, 3);
    reset_n = 1'b0;
    #1;
    check("abort plot", plot_s, 0);
    check("abort busy", busy_s, 0);
    check("abort done", done_s, 0);
    q_s.delete();
    @(negedge CLOCK_50);
    #1 reset_n = 1'b1;
    plots_s = 0;
    push_small(0, 10, 5, COL_GREEN, COL_WHITE, 1'b0);
    launch_small(0, 10, 5, COL_GREEN, COL_WHITE, 1'b0);
    wait_done_small(cyc, first, got);
    check("redraw done cycle", cyc, 11);
    check("redraw first plot cycle", first, 3);
    @(negedge CLOCK_50);
    check("redraw plot count", plots_s, 8);
    check("redraw queue empty", q_s.size(), 0);

    // Default 80x120 at (80,0), ROM_LAT=3
    plots_l = 0;
    for (int r = 0; r < 120; r++) begin
      for (int c = 0; c < 80; c++) begin
        int a;
        a = r*80 + c;
        p.x = 8'(80 + c);
        p.y = 7'(r);
        p.c = (a[0] ^ a[3]) ? 3'b110 : 3'b001;
        q_l.push_back(p);
      end
    end
    @(posedge CLOCK_50);
    #1;
    sel_l = 2'd0; x0_l = 8'd80; y0_l = 7'd0;
    fg_l = 3'b001; bg_l = 3'b110; tr_l = 1'b0; start_l = 1'b1;
    @(posedge CLOCK_50);
    #1 start_l = 1'b0;
    cyc = 0; first = -1; got = 1'b0; n_inc = 0; max_a = 0; prev = -1;
    while (cyc < 12000 && !got) begin
      @(negedge CLOCK_50);
      cyc++;
      if (plot_l && first < 0) first = cyc;
      if (busy_l) begin
        if (int'(rom_addr_l) == prev + 1) n_inc++;
        if (int'(rom_addr_l) > max_a) max_a = int'(rom_addr_l);
        prev = int'(rom_addr_l);
      end
      if (done_l) got = 1'b1;
    end
    if (!got) check("large done timeout", 0, 1);
    check("large done cycle", cyc, 9605);
    check("large first plot cycle", first, 5);
    check("large addr steps", n_inc, 9600);
    check("large max addr", max_a, 9599);
    @(negedge CLOCK_50);
    check("large busy after done", busy_l, 0);
    check("large plot count", plots_l, 9600);
    check("large queue empty", q_l.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
